alu_result_buffer: RTL and testbench

- Registered stage directly downstream of the 32-bit ALU result multiplexer.
- Captures each selected ALU result together with its opcode and operands, and computes status flags (zero, negative, signed overflow, illegal-opcode).
- Queues results in a small FIFO with valid/ready handshakes on both sides, so a stalled consumer (register-file writeback or test harness) does not drop ALU results.
- Keeps a saturating count of results delivered.

---
 rtl/alu_result_buffer.sv | 104 ++++++++++
 tb/tb_alu_result_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: registered FIFO stage behind the ALU result mux, storing result, opcode and status flags.
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready         upstream handshake; in_ready is high while the FIFO is not full
//   in_select, in_a, in_b     opcode and operands that produced in_result
//   in_result                 selected ALU result
//   out_valid/out_ready       downstream handshake on the FIFO head
//   out_result, out_select    head result and opcode (0 while empty)
//   out_zero, out_neg         head result is zero / has its MSB set
//   out_ovf, out_illegal      head signed overflow (add/sub only) / head opcode is illegal
//   count                     saturating number of completed output handshakes
module alu_result_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_select,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_select,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf,
    output logic             out_illegal,
    output logic [CNT_W-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [2:0]       sel;
        logic             zero;
        logic             neg;
        logic             ovf;
        logic             illegal;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           in_entry;
    entry_t           head;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      occ_q, occ_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;
    logic             sa, sb, sr;

    assign sa = in_a[WIDTH-1];
    assign sb = in_b[WIDTH-1];
    assign sr = in_result[WIDTH-1];

    // Flags are computed once at capture so the output side is pure register reads.
    always_comb begin
        in_entry.result  = in_result;
        in_entry.sel     = in_select;
        in_entry.zero    = (in_result == '0);
        in_entry.neg     = sr;
        in_entry.ovf     = (in_select == 3'b000) ? ((sa == sb) && (sr != sa)) :
                           (in_select == 3'b001) ? ((sa != sb) && (sr != sa)) : 1'b0;
        in_entry.illegal = (in_select == 3'b100) || (in_select == 3'b110) || (in_select == 3'b111);
    end

    assign in_ready  = (occ_q != FULL);
    assign out_valid = (occ_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign occ_d     = occ_q + (AW+1)'(push) - (AW+1)'(pop);
    assign count_d   = (pop && count_q != '1) ? count_q + CNT_W'(1) : count_q;

    // Storage is not reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            occ_q   <= occ_d;
            count_q <= count_d;
        end
    end

    assign head        = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_result  = head.result;
    assign out_select  = head.sel;
    assign out_zero    = head.zero;
    assign out_neg     = head.neg;
    assign out_ovf     = head.ovf;
    assign out_illegal = head.illegal;
    assign count       = count_q;
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: randomized and directed checks of alu_result_buffer against a queue model.
module tb_alu_result_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [2:0]  in_select = '0, out_select;
    logic [31:0] in_a = '0, in_b = '0, in_result = '0, out_result;
    logic        out_zero, out_neg, out_ovf, out_illegal;
    logic [15:0] count;

    typedef struct {
        logic [31:0] r;
        logic [2:0]  s;
        bit          z, n, o, il;
    } ent_t;

    ent_t q[$];
    int   mcount = 0;
    int   n_pass = 0, n_total = 0;
    bit   last_push = 0;

    alu_result_buffer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_select(in_select), .in_a(in_a), .in_b(in_b), .in_result(in_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_select(out_select), .out_zero(out_zero), .out_neg(out_neg),
        .out_ovf(out_ovf), .out_illegal(out_illegal), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] alu(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
        case (s)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Overflow is judged by the true mathematical result leaving the signed 32-bit range.
    function automatic ent_t ref_entry(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
        ent_t   e;
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint t  = (s == 3'd0) ? sa + sb : sa - sb;
        e.r  = r;
        e.s  = s;
        e.z  = (r == 0);
        e.n  = $signed(r) < 0;
        e.o  = (s == 3'd0 || s == 3'd1) && (t > 64'sd2147483647 || t < -64'sd2147483648);
        e.il = (s == 3'd4 || s == 3'd6 || s == 3'd7);
        return e;
    endfunction

    task automatic check_outputs();
        ent_t h;
        check("in_ready", in_ready, q.size() < 4);
        check("out_valid", out_valid, q.size() != 0);
        check("count", count, mcount);
        if (q.size() != 0) h = q[0];
        else h = '{r: 0, s: 0, z: 0, n: 0, o: 0, il: 0};
        check("out_result", out_result, h.r);
        check("out_select", out_select, h.s);
        check("out_zero", out_zero, h.z);
        check("out_neg", out_neg, h.n);
        check("out_ovf", out_ovf, h.o);
        check("out_illegal", out_illegal, h.il);
    endtask

    task automatic cycle();
        ent_t e;
        bit   pu, po;
        check_outputs();
        e  = ref_entry(in_select, in_a, in_b, in_result);
        pu = in_valid && q.size() < 4;
        po = q.size() != 0 && out_ready;
        @(posedge clk);
        if (po) begin
            void'(q.pop_front());
            if (mcount < 65535) mcount++;
        end
        if (pu) q.push_back(e);
        last_push = pu;
        @(negedge clk);
    endtask

    task automatic set_in(input bit v, input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
        in_valid  = v;
        in_select = s;
        in_a      = a;
        in_b      = b;
        in_result = alu(s, a, b);
    endtask

    task automatic send(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        set_in(1, s, a, b);
        do begin
            cycle();
            n++;
        end while (!last_push && n < 50);
        if (!last_push) check("send_timeout", 0, 1);
        in_valid = 0;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h7fffffff;
            2: return 32'h80000000;
            3: return 32'hffffffff;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int base, n;
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        rst = 0;
        @(negedge clk);

        out_ready = 1;
        send(3'd0, 32'd5, 32'd7);
        check("add_valid", out_valid, 1);
        check("add_res", out_result, 32'd12);
        check("add_flags", {out_zero, out_neg, out_ovf, out_illegal}, 4'b0000);
        cycle();
        check("add_count", count, 1);

        send(3'd0, 32'h7fffffff, 32'd1);
        check("add_ovf", {out_ovf, out_neg}, 2'b11);
        cycle();
        send(3'd1, 32'h80000000, 32'd1);
        check("sub_ovf", {out_ovf, out_neg}, 2'b10);
        check("sub_res", out_result, 32'h7fffffff);
        cycle();
        send(3'd3, 32'h7fffffff, 32'h7fffffff);
        check("xor_ovf", {out_ovf, out_zero}, 2'b01);
        cycle();
        send(3'd6, 32'h1234, 32'h5678);
        check("illegal", {out_illegal, out_zero}, 2'b11);
        cycle();
        send(3'd5, 32'hfffffffe, 32'd3);
        check("slt", {out_result[0], out_illegal, out_zero, out_ovf}, 4'b1000);
        cycle();

        out_ready = 0;
        base = mcount;
        for (int k = 1; k <= 4; k++) send(3'd0, k, 32'd0);
        set_in(1, 3'd0, 32'd5, 32'd0);
        cycle();
        cycle();
        check("bp_full", in_ready, 0);
        check("bp_head", out_result, 32'd1);
        out_ready = 1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_push && n < 20);
        check("bp_accept5", last_push, 1);
        in_valid = 0;
        repeat (8) cycle();
        check("bp_count", count, base + 5);

        for (int i = 0; i < 400; i++) begin
            int pin = (i < 200) ? 80 : 30;
            int pout = (i < 200) ? 30 : 80;
            if (!(in_valid && !last_push))
                set_in($urandom_range(0, 99) < pin, 3'($urandom_range(0, 7)), rnd_op(), rnd_op());
            out_ready = $urandom_range(0, 99) < pout;
            cycle();
        end
        in_valid = 0;
        out_ready = 1;
        repeat (6) cycle();

        out_ready = 0;
        for (int k = 0; k < 3; k++) send(3'd2, $urandom, $urandom);
        check("pre_rst_valid", out_valid, 1);
        #2 rst = 1;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_ready", in_ready, 1);
        q.delete();
        mcount = 0;
        @(negedge clk);
        rst = 0;
        out_ready = 1;
        send(3'd0, 32'd9, 32'd9);
        check("post_rst_res", out_result, 32'd18);
        cycle();
        check("post_rst_count", count, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
